wb_gpio_multi: RTL and testbench
================================

// Module: wb_gpio_multi
// PURPOSE
// Parametrised Wishbone B4 classic slave: NPORT banks of 32-bit GPIO, one crossbar slave port.
// Per-bank: output register with atomic SET/CLR/TGL aliases, output-enable, 2-flop input synchroniser,
// edge-detect interrupts with W1C status; single OR-reduced irq_o toward the core irq vector.
// Generalises the single-address gpio/gpio1 output slave to N banks, inputs, byte lanes and interrupts.
// PARAMETERS
// BASE_ADDR  32'h1001_0000  window base; slave selected when (wb_adr_i & ADDR_MASK) == BASE_ADDR
// ADDR_MASK  32'hFFFF_F000  window mask; must match crossbar SLAVE_MASK entry
// NPORT      2              number of 32-bit banks, 1..8
// RESET_OUT  32'h0          reset value of every bank OUT register
// IRQ_EDGE   0              0 rising, 1 falling, 2 both edges set IS
// PORTS
// wb_clk_i   in   1          clock
// wb_rst_i   in   1          synchronous reset, active high
// wb_cyc_i   in   1          cycle
// wb_stb_i   in   1          strobe
// wb_we_i    in   1          write enable
// wb_adr_i   in   32         byte address; [4:2] register, [7:5] bank
// wb_sel_i   in   4          byte lane select
// wb_dat_i   in   32         write data
// wb_dat_o   out  32         read data, registered
// wb_ack_o   out  1          normal termination
// wb_err_o   out  1          error termination (bank >= NPORT)
// gpio_o     out  32*NPORT   OUT registers, bank p at [32p+31:32p]
// gpio_oe_o  out  32*NPORT   OE registers, 1 = drive
// gpio_i     in   32*NPORT   asynchronous pin inputs
// irq_o      out  1          |(IS & IE) over all banks, registered
// BEHAVIOUR
// - Reset (sync, high): OUT=RESET_OUT, OE/IE/IS=0, sync flops=0, ack/err/irq=0, dat_o=0.
// - Register map, bank p at p*0x20: 0x00 OUT rw | 0x04 SET w | 0x08 CLR w | 0x0C TGL w
//   | 0x10 OE rw | 0x14 IN ro | 0x18 IE rw | 0x1C IS rw1c. SET/CLR/TGL read as 0.
// - Handshake: req = cyc & stb & addr-hit & ~ack & ~err. Term (ack or err) asserted exactly 1 cycle
//   after req, for 1 cycle; held request gives term every 2nd cycle. No stall, no wait states.
// - Write on req cycle edge; only byte lanes with sel=1 affected. OUT: lane<=dat; SET: OUT|=dat;
//   CLR: OUT&=~dat; TGL: OUT^=dat; IS: bits with dat=1 cleared. Writes to IN ignored, still acked.
// - Read: dat_o registered with ack, full 32 bits regardless of sel; dat_o=0 on err and when idle.
// - Bank index >= NPORT inside window: err_o instead of ack, no state change.
// - Input path: s1<=gpio_i, s2<=s1, s3<=s2. IN reads s2. Rising edge = s2&~s3, falling = ~s2&s3.
//   Pin change before edge k -> IN visible after edge k+1 -> IS bit set at edge k+2.
// - IS set regardless of IE; IE gates irq_o only. Set and W1C clear same cycle: set wins.
// - irq_o registered: rises one cycle after an enabled IS bit sets; falls one cycle after clear.
// - Reset mid-transaction: pending term dropped, no write committed; master must reissue.
// - Address bits [1:0] ignored; offsets outside [7:0] within window alias by bits [7:2].
// TESTING
// 1 Reset: RESET_OUT=32'hA5A5_0000 -> gpio_o bank0 = A5A5_0000, OE/irq/ack = 0 after rst release.
// 2 Byte lanes: write 0x1001_0000 dat=FFFF_FFFF sel=4'b0010 -> OUT=0000_FF00 (from 0), ack 1 cycle later.
// 3 Atomic: OUT=00F0, SET 000F -> 00FF; CLR 00F0 -> 000F; TGL FFFF_FFFF -> FFFF_FFF0.
// 4 IRQ: IE bank1=0x1, gpio_i[32] 0->1 -> IS(0x1001_003C)=1 at edge k+2, irq_o at k+3;
//   W1C 0x1 -> irq_o low 1 cycle after ack; same-cycle new edge keeps IS=1.
// 5 Error: NPORT=2, read 0x1001_0040 -> err_o=1, ack_o=0, dat_o=0, no register changed.
// 6 Back-to-back held stb on OUT reads -> ack pattern 0,1,0,1; reset asserted while req pending -> no ack.

Source files
------------

// File: rtl/wb_gpio_multi_if.sv
// Wishbone B4 classic bus bundle for the multi-bank GPIO slave.
// master drives cyc/stb/we/adr/sel/dat_w; slave returns dat_r/ack/err.
interface wb_gpio_multi_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  modport master (
    output cyc, stb, we, adr, sel, dat_w,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_w,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_gpio_multi.sv
// Wishbone B4 classic slave with NPORT banks of 32-bit GPIO.
// Ports: wb_clk_i/wb_rst_i (sync, high), wb slave bus, gpio_o/gpio_oe_o
// per-bank OUT/OE, gpio_i async pins, irq_o = |(IS & IE) registered.
module wb_gpio_multi #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_F000,
  parameter int          NPORT     = 2,
  parameter logic [31:0] RESET_OUT = 32'h0,
  parameter int          IRQ_EDGE  = 0
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wb_gpio_multi_if.slave       wb,
  output logic [32*NPORT-1:0]  gpio_o,
  output logic [32*NPORT-1:0]  gpio_oe_o,
  input  logic [32*NPORT-1:0]  gpio_i,
  output logic                 irq_o
);

  logic [NPORT-1:0][31:0] out_q, out_d;
  logic [NPORT-1:0][31:0] oe_q, oe_d;
  logic [NPORT-1:0][31:0] ie_q, ie_d;
  logic [NPORT-1:0][31:0] is_q, is_d;
  logic [NPORT-1:0][31:0] s1_q, s2_q, s3_q;
  logic [NPORT-1:0][31:0] ev;

  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        irq_q, irq_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rdata;
  logic [31:0] wmask, wbits;
  logic [2:0]  bank, rsel;
  logic        hit, req, bank_ok, wr;

  assign hit  = (wb.adr & ADDR_MASK) == BASE_ADDR;
  // ack_q/err_q gate req so a held strobe terminates every 2nd cycle
  assign req  = wb.cyc & wb.stb & hit & ~ack_q & ~err_q;
  assign bank = wb.adr[7:5];
  assign rsel = wb.adr[4:2];
  assign bank_ok = {1'b0, bank} < 4'(NPORT);
  assign wr   = req & wb.we & bank_ok;

  assign wmask = {{8{wb.sel[3]}}, {8{wb.sel[2]}},
                  {8{wb.sel[1]}}, {8{wb.sel[0]}}};
  assign wbits = wb.dat_w & wmask;

  always_comb begin
    ev = '0;
    for (int p = 0; p < NPORT; p++) begin
      case (IRQ_EDGE)
        0:       ev[p] = s2_q[p] & ~s3_q[p];
        1:       ev[p] = ~s2_q[p] & s3_q[p];
        default: ev[p] = s2_q[p] ^ s3_q[p];
      endcase
    end
  end

  always_comb begin
    out_d = out_q;
    oe_d  = oe_q;
    ie_d  = ie_q;
    is_d  = is_q;
    rdata = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (bank == 3'(p)) begin
        case (rsel)
          3'd0:    rdata = out_q[p];
          3'd4:    rdata = oe_q[p];
          3'd5:    rdata = s2_q[p];
          3'd6:    rdata = ie_q[p];
          3'd7:    rdata = is_q[p];
          default: rdata = '0;
        endcase
      end
      if (wr && bank == 3'(p)) begin
        case (rsel)
          3'd0: out_d[p] = (out_q[p] & ~wmask) | wbits;
          3'd1: out_d[p] = out_q[p] | wbits;
          3'd2: out_d[p] = out_q[p] & ~wbits;
          3'd3: out_d[p] = out_q[p] ^ wbits;
          3'd4: oe_d[p]  = (oe_q[p] & ~wmask) | wbits;
          3'd6: ie_d[p]  = (ie_q[p] & ~wmask) | wbits;
          3'd7: is_d[p]  = is_q[p] & ~wbits;
          default: ;
        endcase
      end
      // OR-ing after the W1C clear lets a new edge win
      is_d[p] = is_d[p] | ev[p];
    end
  end

  assign ack_d = req & bank_ok;
  assign err_d = req & ~bank_ok;
  assign dat_d = (ack_d && !wb.we) ? rdata : 32'h0;
  assign irq_d = |(is_q & ie_q);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_q <= {NPORT{RESET_OUT}};
      oe_q  <= '0;
      ie_q  <= '0;
      is_q  <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      irq_q <= 1'b0;
      dat_q <= '0;
    end else begin
      out_q <= out_d;
      oe_q  <= oe_d;
      ie_q  <= ie_d;
      is_q  <= is_d;
      s1_q  <= gpio_i;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      ack_q <= ack_d;
      err_q <= err_d;
      irq_q <= irq_d;
      dat_q <= dat_d;
    end
  end

  assign wb.ack    = ack_q;
  assign wb.err    = err_q;
  assign wb.dat_r  = dat_q;
  assign gpio_o    = out_q;
  assign gpio_oe_o = oe_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_gpio_multi.sv
// Scoreboard bench for wb_gpio_multi: driver pushes expected
// terminations, a negedge monitor pops and compares them.
module tb_wb_gpio_multi;
  localparam int NP = 2;
  localparam logic [31:0] RST_OUT = 32'hA5A5_0000;
  localparam logic [31:0] BASE = 32'h1001_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [32*NP-1:0] gpio_o, gpio_oe_o;
  logic [32*NP-1:0] gpio_i;
  logic irq_o;

  wb_gpio_multi_if bus();

  wb_gpio_multi #(
    .NPORT(NP),
    .RESET_OUT(RST_OUT)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (bus),
    .gpio_o   (gpio_o),
    .gpio_oe_o(gpio_oe_o),
    .gpio_i   (gpio_i),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    int          cyc;
    logic        ack;
    logic        err;
    logic        chk;
    logic [31:0] dat;
    string       name;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] m_out[NP], m_oe[NP], m_ie[NP];
  logic [31:0] m_is[NP], m_in[NP];
  int          pend_bank = -1;
  logic [31:0] pend_bits = '0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++)
      if (s[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NP; b++) begin
      m_out[b] = RST_OUT;
      m_oe[b] = '0;
      m_ie[b] = '0;
      m_is[b] = '0;
      m_in[b] = gpio_i[32*b +: 32];
    end
  endtask

  function automatic logic model_irq();
    logic r;
    r = 1'b0;
    for (int b = 0; b < NP; b++) r = r | (|(m_is[b] & m_ie[b]));
    return r;
  endfunction

  // Register map semantics applied to the model; returns read data.
  task automatic model_access(input logic we,
                              input logic [31:0] adr,
                              input logic [3:0] sel,
                              input logic [31:0] dat,
                              output logic er,
                              output logic [31:0] rd);
    int b, r;
    logic [31:0] m, d;
    b = int'(adr[7:5]);
    r = int'(adr[4:2]);
    m = lanes(sel);
    d = dat & m;
    rd = '0;
    er = (b >= NP);
    if (!er && !we) begin
      if (r == 0) rd = m_out[b];
      else if (r == 4) rd = m_oe[b];
      else if (r == 5) rd = m_in[b];
      else if (r == 6) rd = m_ie[b];
      else if (r == 7) rd = m_is[b];
    end else if (!er) begin
      if (r == 0) m_out[b] = (m_out[b] & ~m) | d;
      else if (r == 1) m_out[b] = m_out[b] | d;
      else if (r == 2) m_out[b] = m_out[b] & ~d;
      else if (r == 3) m_out[b] = m_out[b] ^ d;
      else if (r == 4) m_oe[b] = (m_oe[b] & ~m) | d;
      else if (r == 6) m_ie[b] = (m_ie[b] & ~m) | d;
      else if (r == 7) m_is[b] = m_is[b] & ~d;
    end
  endtask

  task automatic check_state(input string nm);
    for (int b = 0; b < NP; b++) begin
      check({nm, "_out"}, gpio_o[32*b +: 32], m_out[b]);
      check({nm, "_oe"}, gpio_oe_o[32*b +: 32], m_oe[b]);
    end
    check({nm, "_irq"}, {31'b0, irq_o}, {31'b0, model_irq()});
    check({nm, "_idle_dat"}, bus.dat_r, 32'h0);
  endtask

  task automatic xfer(input logic we,
                      input logic [31:0] adr,
                      input logic [3:0] sel,
                      input logic [31:0] dat,
                      input string nm);
    exp_t e;
    logic er;
    logic [31:0] rd;
    model_access(we, adr, sel, dat, er, rd);
    @(posedge clk);
    #1;
    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    bus.we = we;
    bus.adr = adr;
    bus.sel = sel;
    bus.dat_w = dat;
    e.cyc = cyc_n + 1;
    e.ack = ~er;
    e.err = er;
    e.chk = ~we | er;
    e.dat = rd;
    e.name = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we = 1'b0;
    if (pend_bank >= 0) begin
      m_is[pend_bank] = m_is[pend_bank] | pend_bits;
      pend_bank = -1;
    end
    @(posedge clk);
    @(negedge clk);
    check_state(nm);
  endtask

  task automatic pin_step(input logic [32*NP-1:0] nv);
    logic [32*NP-1:0] ov;
    ov = gpio_i;
    @(posedge clk);
    #1;
    gpio_i = nv;
    repeat (4) @(posedge clk);
    for (int b = 0; b < NP; b++) begin
      m_is[b] = m_is[b] | (nv[32*b +: 32] & ~ov[32*b +: 32]);
      m_in[b] = nv[32*b +: 32];
    end
    @(negedge clk);
    check_state("pins");
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.ack || bus.err) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_term: ack=%b err=%b at cycle %0d",
                   bus.ack, bus.err, cyc_n);
        end else begin
          e = q.pop_front();
          if (cyc_n != e.cyc || bus.ack !== e.ack ||
              bus.err !== e.err ||
              (e.chk && bus.dat_r !== e.dat)) begin
            errors++;
            $display("FAIL %s: got cyc=%0d ack=%b err=%b dat=%h expected cyc=%0d ack=%b err=%b dat=%h",
                     e.name, cyc_n, bus.ack, bus.err, bus.dat_r,
                     e.cyc, e.ack, e.err, e.dat);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int c;
    logic [31:0] a;
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we = 1'b0;
    bus.adr = '0;
    bus.sel = '0;
    bus.dat_w = '0;
    gpio_i = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_out0", gpio_o[31:0], RST_OUT);
    check("rst_out1", gpio_o[63:32], RST_OUT);
    check("rst_oe", gpio_oe_o[31:0], 32'h0);
    check("rst_irq", {31'b0, irq_o}, 32'h0);
    check("rst_ack", {30'b0, bus.ack, bus.err}, 32'h0);

    xfer(1, BASE, 4'b0010, 32'hFFFF_FFFF, "bytelane");
    xfer(1, BASE, 4'hF, 32'h0000_00F0, "out_wr");
    xfer(1, BASE + 32'h04, 4'hF, 32'h0000_000F, "set");
    xfer(0, BASE, 4'h0, 32'h0, "rd_after_set");
    xfer(1, BASE + 32'h08, 4'hF, 32'h0000_00F0, "clr");
    xfer(1, BASE + 32'h0C, 4'hF, 32'hFFFF_FFFF, "tgl");
    xfer(0, BASE, 4'h1, 32'h0, "rd_after_tgl");
    xfer(0, BASE + 32'h04, 4'hF, 32'h0, "rd_set_zero");

    xfer(1, BASE + 32'h38, 4'hF, 32'h1, "ie1");
    @(posedge clk);
    #1;
    gpio_i[32] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("irq_k1", {31'b0, irq_o}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("irq_k2", {31'b0, irq_o}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("irq_k3", {31'b0, irq_o}, 32'h1);
    m_is[1] = m_is[1] | 32'h1;
    m_in[1] = 32'h1;
    xfer(0, BASE + 32'h3C, 4'hF, 32'h0, "rd_is1");
    xfer(0, BASE + 32'h34, 4'hF, 32'h0, "rd_in1");
    xfer(1, BASE + 32'h3C, 4'hF, 32'h1, "w1c");
    pin_step({32'h0, gpio_i[31:0]});
    @(posedge clk);
    #1;
    gpio_i[32] = 1'b1;
    m_in[1] = 32'h1;
    @(posedge clk);
    pend_bank = 1;
    pend_bits = 32'h1;
    xfer(1, BASE + 32'h3C, 4'hF, 32'h1, "w1c_setwins");
    xfer(0, BASE + 32'h3C, 4'hF, 32'h0, "rd_is_kept");

    xfer(0, BASE + 32'h40, 4'hF, 32'h0, "err_rd");
    xfer(1, BASE + 32'hE0, 4'hF, 32'hFFFF_FFFF, "err_wr");
    xfer(0, BASE + 32'h103, 4'hF, 32'h0, "alias_rd");

    @(posedge clk);
    #1;
    c = cyc_n;
    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    bus.we = 1'b0;
    bus.adr = BASE;
    bus.sel = 4'hF;
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      e.cyc = c + 1 + 2 * i;
      e.ack = 1'b1;
      e.err = 1'b0;
      e.chk = 1'b1;
      e.dat = m_out[0];
      e.name = "held_rd";
      q.push_back(e);
    end
    repeat (4) @(posedge clk);
    #1;
    bus.cyc = 1'b0;
    bus.stb = 1'b0;

    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 9) < 3) begin
        pin_step({$urandom, $urandom});
      end else begin
        a = BASE | ($urandom_range(0, 15) << 8) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0)
          a[7:5] = 3'($urandom_range(2, 7));
        else
          a[7:5] = 3'($urandom_range(0, 1));
        a[4:2] = 3'($urandom_range(0, 7));
        xfer(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)),
             $urandom, "rand");
      end
    end

    pin_step('0);
    xfer(1, BASE + 32'h3C, 4'hF, 32'hFFFF_FFFF, "clr_is0");
    xfer(1, BASE + 32'h38, 4'hF, 32'h0, "clr_ie1");
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    bus.we = 1'b1;
    bus.adr = BASE;
    bus.sel = 4'hF;
    bus.dat_w = 32'h1234_5678;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_mid_noack", {31'b0, bus.ack}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check_state("rst_mid");
    xfer(0, BASE, 4'hF, 32'h0, "after_rst_rd");

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_term: got %0d pending expected 0",
               q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
